// File: rtl/word_packer.sv
// word_packer: collects up to four K_DWIDTH-bit words into one packed group.
//
// Words accepted while filling are written to consecutive lanes (lane n holds
// the n-th accepted word) and flagged in o_mask. The group is offered
// downstream once the fourth word lands or a flush is requested for a
// non-empty group. While a group is offered, no input is taken, and the
// group stays frozen until the downstream side takes it.
//
// Optional feature: define WORD_PACKER_TIMEOUT_EN to add an idle counter
// that auto-flushes a partial group after K_TIMEOUT idle cycles. When the
// macro is undefined, K_TIMEOUT only has to be a legal value (at least 1).
//
// Parameters:
//   K_DWIDTH  - width of one data word (lane)
//   K_TIMEOUT - idle cycles before auto-flush (timeout build only)
//
// Ports:
//   i_clk    - clock, rising edge
//   i_rst_n  - asynchronous active-low reset
//   i_valid  - upstream word valid
//   o_ready  - block accepts a word this cycle
//   i_word   - upstream data word
//   i_flush  - emit a partially filled group
//   o_valid  - packed group available
//   i_ready  - downstream accepts the group
//   o_mem    - packed group, lane n = n-th accepted word, unwritten lanes zero
//   o_mask   - per-lane written flags
module word_packer #(
    parameter int unsigned K_DWIDTH  = 8,
    parameter int unsigned K_TIMEOUT = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [K_DWIDTH-1:0]      i_word,
    input  logic                     i_flush,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [3:0][K_DWIDTH-1:0] o_mem,
    output logic [3:0]               o_mask
);

    localparam int unsigned LANES = 4;
    localparam int unsigned CNT_W = 2;

    // Reject parameter values that cannot build a working packer.
    if (K_DWIDTH == 0) begin : g_bad_dwidth
        $error("word_packer: K_DWIDTH must be at least 1");
    end
    if (K_TIMEOUT == 0) begin : g_bad_timeout
        $error("word_packer: K_TIMEOUT must be at least 1");
    end

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [LANES-1:0][K_DWIDTH-1:0] mem_q, mem_d;
    logic [LANES-1:0]               mask_q, mask_d;
    logic                           valid_q, valid_d;
    logic                           ready_q, ready_d;

    logic accept_c;
    logic flush_req_c;

`ifdef WORD_PACKER_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(K_TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              timeout_c;

    // Idle counter: runs only while a partial group waits with no new word.
    always_comb begin
        idle_d    = idle_q;
        timeout_c = 1'b0;
        if (state_q == ST_HOLD || accept_c) begin
            idle_d = '0;
        end else if (cnt_q != '0) begin
            idle_d    = idle_q + IDLE_W'(1);
            timeout_c = (idle_d == IDLE_W'(K_TIMEOUT));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end

    assign flush_req_c = i_flush | timeout_c;
`else
    assign flush_req_c = i_flush;
`endif

    // A word is taken only while filling; nothing bypasses a held group.
    assign accept_c = i_valid && (state_q == ST_FILL);

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        mask_d  = mask_q;
        valid_d = valid_q;
        ready_d = ready_q;

        unique case (state_q)
            ST_FILL: begin
                if (accept_c) begin
                    mem_d[cnt_q]  = i_word;
                    mask_d[cnt_q] = 1'b1;
                    cnt_d         = cnt_q + CNT_W'(1);
                end
                // A same-cycle word makes an otherwise empty group flushable.
                if ((accept_c && cnt_q == CNT_W'(LANES - 1)) ||
                    (flush_req_c && (cnt_q != '0 || accept_c))) begin
                    state_d = ST_HOLD;
                    valid_d = 1'b1;
                    ready_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (i_ready) begin
                    state_d = ST_FILL;
                    cnt_d   = '0;
                    mem_d   = '0;
                    mask_d  = '0;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_FILL;
                cnt_d   = '0;
                mem_d   = '0;
                mask_d  = '0;
                valid_d = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_FILL;
            cnt_q   <= '0;
            mem_q   <= '0;
            mask_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
            mask_q  <= mask_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign o_mem   = mem_q;
    assign o_mask  = mask_q;
    assign o_valid = valid_q;
    assign o_ready = ready_q;

endmodule

// File: tb/tb_word_packer.sv
// Testbench for word_packer: a group-level reference model checked against
// the DUT on every falling edge, plus directed scenarios with literal values.
module tb_word_packer;

    localparam int unsigned DW = 8;
    localparam int unsigned TO = 4;

    logic            clk;
    logic            rst_n;
    logic            i_valid;
    logic            o_ready;
    logic [DW-1:0]   i_word;
    logic            i_flush;
    logic            o_valid;
    logic            i_ready;
    logic [3:0][DW-1:0] o_mem;
    logic [3:0]      o_mask;

    int checks;
    int errors;
    bit cmp_en;

    word_packer #(.K_DWIDTH(DW), .K_TIMEOUT(TO)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_word  (i_word),
        .i_flush (i_flush),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_mem   (o_mem),
        .o_mask  (o_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a group is a list of words (count 0..4) plus an
    // "offered" flag; words join only while not offered.
    logic [DW-1:0] m_words [4];
    int            m_n;
    bit            m_offered;
    int            m_idle;

    always @(posedge clk or negedge rst_n) begin : model
        int  n_new;
        bit  take;
        bit  tmo;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_words[i] <= '0;
            m_n       <= 0;
            m_offered <= 1'b0;
            m_idle    <= 0;
        end else if (m_offered) begin
            m_idle <= 0;
            if (i_ready) begin
                for (int i = 0; i < 4; i++) m_words[i] <= '0;
                m_n       <= 0;
                m_offered <= 1'b0;
            end
        end else begin
            take  = i_valid;
            n_new = m_n + (take ? 1 : 0);
            tmo   = 1'b0;
`ifdef WORD_PACKER_TIMEOUT_EN
            if (!take && m_n > 0) tmo = (m_idle + 1 >= TO);
            m_idle <= (take || m_n == 0) ? 0 : m_idle + 1;
`endif
            if (take) m_words[m_n] <= i_word;
            m_n <= n_new;
            if (n_new == 4 || ((i_flush || tmo) && n_new > 0)) m_offered <= 1'b1;
        end
    end

    // Compare process: every falling edge once checking is enabled.
    always @(negedge clk) begin
        logic [3:0][DW-1:0] e_mem;
        logic [3:0]         e_mask;
        if (cmp_en) begin
            for (int i = 0; i < 4; i++) begin
                e_mem[i]  = (i < m_n) ? m_words[i] : '0;
                e_mask[i] = (i < m_n);
            end
            chk("model_valid", 32'(o_valid), 32'(m_offered));
            chk("model_ready", 32'(o_ready), 32'(!m_offered));
            chk("model_mask",  32'(o_mask),  32'(e_mask));
            chk("model_mem",   32'(o_mem),   32'(e_mem));
        end
    end

    // Apply one cycle of inputs, return just after the rising edge.
    task automatic step(input bit v, input logic [DW-1:0] w, input bit f, input bit r);
        i_valid = v;
        i_word  = w;
        i_flush = f;
        i_ready = r;
        @(posedge clk);
        #1;
    endtask

    // Move to just after the next falling edge for literal checks.
    task automatic mid;
        @(negedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        cmp_en  = 1'b0;
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_word  = '0;
        i_flush = 1'b0;
        i_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_ready", 32'(o_ready), 32'h1);
        chk("rst_valid", 32'(o_valid), 32'h0);
        chk("rst_mask",  32'(o_mask),  32'h0);
        chk("rst_mem",   32'(o_mem),   32'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        step(0, 8'h00, 0, 1);

        // Full group, downstream ready
        step(1, 8'h11, 0, 1);
        step(1, 8'h22, 0, 1);
        step(1, 8'h33, 0, 1);
        step(1, 8'h44, 0, 1);
        i_valid = 1'b0;
        mid();
        chk("full_valid", 32'(o_valid), 32'h1);
        chk("full_ready", 32'(o_ready), 32'h0);
        chk("full_mem",   32'(o_mem),   32'h44332211);
        chk("full_mask",  32'(o_mask),  32'hF);
        step(0, 8'h00, 0, 1);
        mid();
        chk("full_valid_1cyc", 32'(o_valid), 32'h0);
        chk("full_ready_back", 32'(o_ready), 32'h1);
        chk("full_clear_mask", 32'(o_mask),  32'h0);

        // Backpressure: held for 10 cycles while extra words are offered
        step(1, 8'hB1, 0, 0);
        step(1, 8'hB2, 0, 0);
        step(1, 8'hB3, 0, 0);
        step(1, 8'hB4, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 8'hEE, 0, 0);
            mid();
            chk("bp_valid", 32'(o_valid), 32'h1);
            chk("bp_ready", 32'(o_ready), 32'h0);
            chk("bp_mem",   32'(o_mem),   32'hB4B3B2B1);
            chk("bp_mask",  32'(o_mask),  32'hF);
        end
        step(0, 8'h00, 0, 1);
        mid();
        chk("bp_release", 32'(o_valid), 32'h0);

        // Flush of a two-word group
        step(1, 8'hA1, 0, 1);
        step(1, 8'hA2, 0, 1);
        step(0, 8'h00, 1, 1);
        i_flush = 1'b0;
        mid();
        chk("flush_valid", 32'(o_valid), 32'h1);
        chk("flush_mask",  32'(o_mask),  32'h3);
        chk("flush_mem",   32'(o_mem),   32'h0000A2A1);
        step(0, 8'h00, 0, 1);

        // Flush with a same-cycle third word
        step(1, 8'hA1, 0, 1);
        step(1, 8'hA2, 0, 1);
        step(1, 8'hA3, 1, 1);
        i_valid = 1'b0;
        i_flush = 1'b0;
        mid();
        chk("flush3_mask", 32'(o_mask), 32'h7);
        chk("flush3_mem",  32'(o_mem),  32'h00A3A2A1);
        step(0, 8'h00, 0, 1);

        // Flush of an empty group is ignored
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h00, 1, 1);
            mid();
            chk("eflush_valid", 32'(o_valid), 32'h0);
            chk("eflush_ready", 32'(o_ready), 32'h1);
        end
        step(0, 8'h00, 0, 1);

        // Reset pulse between edges with a partial group
        step(1, 8'hC1, 0, 1);
        step(1, 8'hC2, 0, 1);
        i_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_mask",  32'(o_mask),  32'h0);
        chk("mrst_mem",   32'(o_mem),   32'h0);
        chk("mrst_ready", 32'(o_ready), 32'h1);
        #1;
        rst_n = 1'b1;
        step(1, 8'hD1, 0, 1);
        step(1, 8'hD2, 0, 1);
        step(1, 8'hD3, 0, 1);
        step(1, 8'hD4, 0, 1);
        i_valid = 1'b0;
        mid();
        chk("mrst_grp_mask", 32'(o_mask), 32'hF);
        chk("mrst_grp_mem",  32'(o_mem),  32'hD4D3D2D1);
        step(0, 8'h00, 0, 1);

        // Timeout on a single-word group
        step(1, 8'h5A, 0, 1);
`ifdef WORD_PACKER_TIMEOUT_EN
        for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 1);
        mid();
        chk("to_early", 32'(o_valid), 32'h0);
        step(0, 8'h00, 0, 1);
        mid();
        chk("to_valid", 32'(o_valid), 32'h1);
        chk("to_mask",  32'(o_mask),  32'h1);
        chk("to_mem",   32'(o_mem),   32'h0000005A);
        step(0, 8'h00, 0, 1);
`else
        for (int i = 0; i < 100; i++) step(0, 8'h00, 0, 1);
        mid();
        chk("noto_valid", 32'(o_valid), 32'h0);
        chk("noto_mask",  32'(o_mask),  32'h1);
        step(0, 8'h00, 1, 1);
        i_flush = 1'b0;
        mid();
        chk("noto_flush", 32'(o_valid), 32'h1);
        step(0, 8'h00, 0, 1);
`endif
        step(0, 8'h00, 0, 1);
        mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
